joy_serial_tx: RTL and testbench
================================

# joy_serial_tx

Serial transmitter for the two-player joystick shift-register link. It is the device-side counterpart of the joystick reader in the arcade top levels. It takes two parallel 12-bit active-low joystick words and drives `joy_data` in step with an externally generated `joy_clk`/`joy_load` pair, emulating the parallel-in/serial-out register chain on the joystick adapter. It serves as the adapter-side logic for a USB/PS2-to-DB9 bridge core and as the bus-functional model in the reader's testbench.

## Interface
- `PAD_BITS`, default 1: number of filler `1` bits emitted after load release, before frame bit 0.
- `FRAME_BITS`, default 24: payload bits per frame. Fixed by the bit order below; other values are illegal.
- `clk` in 1: system clock. Must be at least 8× the `joy_clk` frequency.
- `reset_n` in 1: one clock; reset is synchronous and active-low.
- `joy1` in 12: player-1 word, active low. Bits are [0] up, [1] down, [2] left, [3] right, [4..7] fire, [8] start, [9] coin, [10] mode, [11] reset.
- `joy2` in 12: player-2 word, same layout as `joy1`.
- `joy_clk` in 1: shift clock from the reader. Asynchronous to `clk`.
- `joy_load` in 1: parallel load from the reader. Asynchronous to `clk`; low means load.
- `joy_data` out 1: serial data to the reader. Registered.
- `frame_done` out 1: one-`clk` pulse when the last payload bit has been shifted past.
- `short_frame` out 1: one-`clk` pulse when `joy_load` falls before the frame completes.

## Operation
- `joy_clk` and `joy_load` each pass through a 2-flop synchronizer. A third flop provides edge detection.
  - `clk_fall` = synced `joy_clk` 1→0.
  - `load_fall` / `load_rise` = synced `joy_load` edges.
- Frame order, bit 0 first: j1[8], j1[6], j1[5], j1[4], j1[3], j1[2], j1[1], j1[0], j2[8], j2[6], j2[5], j2[4], j2[3], j2[2], j2[1], j2[0], j2[10], j2[11], j2[9], j2[7], j1[10], j1[11], j1[9], j1[7].
- Shift register width is PAD_BITS+FRAME_BITS. The PAD ones sit at the output end. The serial-in fill is `1`.
- `bit_cnt` is 0..PAD_BITS+FRAME_BITS, 5 bits wide, and saturates at the maximum. It is internal.
- FSM states:
  - IDLE: entered from reset. `joy_data`=1. On synced load low → LOAD.
  - LOAD: synced load low. Every `clk`, the shift register is loaded from live `joy1`/`joy2` and `bit_cnt`=0. `joy_data` = shift-register output bit. `clk_fall` is ignored. On `load_rise` → SHIFT, with the word captured on the final LOAD cycle frozen.
  - SHIFT: on each `clk_fall`, shift one position toward the output and increment `bit_cnt`. When `bit_cnt` reaches PAD_BITS+FRAME_BITS → DONE and pulse `frame_done`. On `load_fall` → LOAD and pulse `short_frame`.
  - DONE: `joy_data`=1. `clk_fall` is ignored. On `load_fall` → LOAD, with no `short_frame` pulse.
- Load has priority. If `load_fall` and `clk_fall` occur on the same `clk`, the shift is discarded and the FSM enters LOAD.
- Inputs change mid-frame: no effect until the next LOAD.
- Reset mid-frame: the FSM returns to IDLE on the next `clk`. A subsequent load starts a clean frame.

## Timing
- Reset values:
  - `joy_data`=1, `frame_done`=0, `short_frame`=0.
  - FSM=IDLE, `bit_cnt`=0, shift register all ones, synchronizers all ones.
- Latency from a pin edge to its effect is 3 `clk` (2 sync stages plus the edge register). Examples: `joy_clk` falling pin edge → new `joy_data`; `joy_load` edge → state change.
- `joy_data` changes only after a `joy_clk` falling edge or a load event. It is stable across the reader's rising-edge sample provided `joy_clk` half-period > 4 `clk`.
- `frame_done` and `short_frame` fire on the same `clk` as the state transition that causes them.
- A full frame needs PAD_BITS+FRAME_BITS falling edges after load release.

## Test plan
- Reset held 3 cycles with toggling inputs → `joy_data`=1 and no pulses. After release, still 1 until the first load.
- `joy1`=12'hFFE (up pressed), `joy2`=12'hFFF, PAD_BITS=1. Load pulse, then 25 `joy_clk` falls → serial stream is 1 (pad), 1,1,1,1,1,1,1,0 (j1[0] at bit 8), then all ones. `frame_done` pulses once after the 25th fall.
- `joy2`=12'h7FF (j2[11] low) → the 0 appears at payload position 17. Changing `joy2` to FFF mid-frame does not alter the stream.
- Load reasserted after 10 falls → `short_frame` pulses once, state is LOAD, and the next frame restarts from the pad bit.
- `load_fall` coincident with `clk_fall` → no shift occurs, the LOAD state is entered, and the output equals the pad bit 1.
- Reference loop: connect to the top-level joystick reader at the production `joy_clk` rate with random `joy1`/`joy2` values over 100 frames → the reader's `joystick1`/`joystick2` equal the driven words in all 24 mapped bits.

Source files
------------

// File: rtl/joy_serial_tx_if.sv
// joy_serial_tx_if
//   Three-wire joystick shift-register link between a reader (master) and
//   the adapter-side transmitter (slave).
//
//   joy_clk  : shift clock, driven by the reader
//   joy_load : parallel load, driven by the reader, low = load
//   joy_data : serial data, driven by the transmitter
//
// Link semantics: there is no valid/ready pair on this link. The reader owns
// both timing wires and the transmitter only follows them. While joy_load is
// low the transmitter keeps re-capturing its parallel words. Releasing
// joy_load freezes the word. Each falling joy_clk edge afterwards advances
// joy_data by one bit, and the reader samples joy_data on the rising edge.
interface joy_serial_tx_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input joy_data);
    modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_serial_tx.sv
// joy_serial_tx
//   Adapter-side transmitter for the two-player joystick shift-register link.
//   It emulates the parallel-in/serial-out register chain: the reader pulses
//   joy_load low, releases it, then clocks out PAD_BITS filler ones followed
//   by a 24-bit payload on falling joy_clk edges.
//
// Ports
//   clk, reset_n : system clock, synchronous active-low reset
//   joy1, joy2   : 12-bit active-low player words
//   link         : joy_clk / joy_load in, registered joy_data out
//   frame_done   : one-clk pulse after the last payload bit was shifted past
//   short_frame  : one-clk pulse when a load interrupts a frame in progress
//   dbg_state    : current FSM state (0 idle, 1 load, 2 shift, 3 done)
module joy_serial_tx #(
    parameter int PAD_BITS   = 1,
    parameter int FRAME_BITS = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [11:0]       joy1,
    input  logic [11:0]       joy2,
    joy_serial_tx_if.slave    link,
    output logic              frame_done,
    output logic              short_frame,
    output logic [1:0]        dbg_state
);

    localparam int SR_W = PAD_BITS + FRAME_BITS;
    localparam logic [4:0] CNT_MAX = 5'(SR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        clk_sync_q, clk_sync_d;
    logic [2:0]        ld_sync_q, ld_sync_d;
    logic              joy_data_q, joy_data_d;
    logic              frame_done_q, frame_done_d;
    logic              short_frame_q, short_frame_d;

    logic [23:0]       frame_word;
    logic [SR_W-1:0]   load_word;
    logic              clk_fall;
    logic              load_fall;
    logic              load_rise;
    logic              load_low;

    // Payload bit 0 is the first bit out after the pad; the MSB here is bit 23.
    assign frame_word = {joy1[7], joy1[9], joy1[11], joy1[10],
                         joy2[7], joy2[9], joy2[11], joy2[10],
                         joy2[0], joy2[1], joy2[2], joy2[3],
                         joy2[4], joy2[5], joy2[6], joy2[8],
                         joy1[0], joy1[1], joy1[2], joy1[3],
                         joy1[4], joy1[5], joy1[6], joy1[8]};

    // Pad ones sit at the output end so they leave first.
    assign load_word = {frame_word, {PAD_BITS{1'b1}}};

    // Bit [1] is the synchronized level; bit [2] is its previous value.
    assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
    assign load_fall = ld_sync_q[2]  & ~ld_sync_q[1];
    assign load_rise = ~ld_sync_q[2] &  ld_sync_q[1];
    assign load_low  = ~ld_sync_q[1];

    always_comb begin
        clk_sync_d    = {clk_sync_q[1:0], link.joy_clk};
        ld_sync_d     = {ld_sync_q[1:0], link.joy_load};
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_low) begin
                    state_d = ST_LOAD;
                    sr_d    = load_word;
                    cnt_d   = 5'd0;
                end
            end
            ST_LOAD: begin
                // Keep tracking the live words until release; the word taken
                // on the last load cycle is the one that gets shifted.
                if (load_rise) begin
                    state_d = ST_SHIFT;
                end else begin
                    sr_d  = load_word;
                    cnt_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                // A new load wins over a coincident shift.
                if (load_fall) begin
                    state_d       = ST_LOAD;
                    sr_d          = load_word;
                    cnt_d         = 5'd0;
                    short_frame_d = 1'b1;
                end else if (clk_fall) begin
                    sr_d  = {1'b1, sr_q[SR_W-1:1]};
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;
                    if (cnt_q == CNT_MAX - 5'd1) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (load_fall) begin
                    state_d = ST_LOAD;
                    sr_d    = load_word;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output is registered from next-state values so it moves together
        // with the shift register.
        joy_data_d = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? sr_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sr_q          <= '1;
            cnt_q         <= 5'd0;
            clk_sync_q    <= 3'b111;
            ld_sync_q     <= 3'b111;
            joy_data_q    <= 1'b1;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            clk_sync_q    <= clk_sync_d;
            ld_sync_q     <= ld_sync_d;
            joy_data_q    <= joy_data_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign link.joy_data = joy_data_q;
    assign frame_done    = frame_done_q;
    assign short_frame   = short_frame_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_joy_serial_tx.sv
// tb_joy_serial_tx
//   Bench for joy_serial_tx. The reference keeps the expected serial stream
//   as a queue of bits built from the frame bit-order table, and applies pin
//   events three clk cycles after the bench drives them.
module tb_joy_serial_tx;

    localparam int PAD = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] joy1 = 12'hFFF;
    logic [11:0] joy2 = 12'hFFF;
    logic        frame_done;
    logic        short_frame;
    logic [1:0]  dbg_state;

    joy_serial_tx_if link();

    joy_serial_tx #(.PAD_BITS(PAD), .FRAME_BITS(24)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .joy1        (joy1),
        .joy2        (joy2),
        .link        (link),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    bit rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc++;
        rst_at_edge = reset_n;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame bit k comes from {joy2, joy1}[map_idx[k]] (0..11 joy1, 12..23 joy2).
    int map_idx [24] = '{8, 6, 5, 4, 3, 2, 1, 0,
                         20, 18, 17, 16, 15, 14, 13, 12,
                         22, 23, 21, 19, 10, 11, 9, 7};

    function automatic logic [23:0] frame_of(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] both;
        logic [23:0] w;
        both = {b, a};
        for (int k = 0; k < 24; k++) w[k] = both[map_idx[k]];
        return w;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [0:0] exp_q[$];
    int  ev_due[$];
    int  ev_kind[$];          // 0 clk fall, 1 load fall, 2 load rise
    bit  m_shifting = 1'b0;
    int  fd_count = 0;
    int  sf_count = 0;

    always @(negedge clk) begin : compare
        bit          saw_load;
        bit          saw_fall;
        bit          exp_fd;
        bit          exp_sf;
        logic        exp_data;
        int          kind;
        logic [23:0] f;
        saw_load = 1'b0;
        saw_fall = 1'b0;
        exp_fd   = 1'b0;
        exp_sf   = 1'b0;
        if (!rst_at_edge) begin
            exp_q.delete();
            ev_due.delete();
            ev_kind.delete();
            m_shifting = 1'b0;
        end else begin
            while (ev_due.size() > 0 && ev_due[0] <= cyc) begin
                kind = ev_kind.pop_front();
                void'(ev_due.pop_front());
                if (kind == 0) begin
                    saw_fall = 1'b1;
                end else if (kind == 1) begin
                    saw_load = 1'b1;
                    if (m_shifting) exp_sf = 1'b1;
                    m_shifting = 1'b0;
                    exp_q.delete();
                end else begin
                    saw_load = 1'b1;
                    m_shifting = 1'b1;
                    exp_q.delete();
                    f = frame_of(joy1, joy2);
                    for (int p = 0; p < PAD; p++) exp_q.push_back(1'b1);
                    for (int k = 0; k < 24; k++) exp_q.push_back(f[k]);
                end
            end
            if (saw_fall && !saw_load && m_shifting) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_shifting = 1'b0;
                    exp_fd = 1'b1;
                end
            end
        end
        exp_data = (m_shifting && exp_q.size() > 0) ? exp_q[0] : 1'b1;
        chk("joy_data", 32'(link.joy_data), 32'(exp_data));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("short_frame", 32'(short_frame), 32'(exp_sf));
        if (frame_done === 1'b1) fd_count++;
        if (short_frame === 1'b1) sf_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pins(input logic lc, input logic ll);
        @(negedge clk);
        if (link.joy_clk === 1'b1 && lc == 1'b0) begin
            ev_due.push_back(cyc + 3);
            ev_kind.push_back(0);
        end
        if (link.joy_load !== ll) begin
            ev_due.push_back(cyc + 3);
            ev_kind.push_back(ll ? 2 : 1);
        end
        link.joy_clk  = lc;
        link.joy_load = ll;
    endtask

    task automatic set_clk(input logic v);
        drive_pins(v, link.joy_load);
    endtask

    task automatic set_load(input logic v);
        drive_pins(link.joy_clk, v);
    endtask

    task automatic clk_pulse(input int h);
        set_clk(1'b0);
        wait_cyc(h - 1);
        set_clk(1'b1);
        wait_cyc(h - 1);
    endtask

    task automatic load_pulse(input int low);
        set_load(1'b0);
        wait_cyc(low - 1);
        set_load(1'b1);
        wait_cyc(5);
    endtask

    task automatic do_reset(input int n, input bit toggle);
        @(negedge clk);
        reset_n = 1'b0;
        link.joy_clk = 1'b1;
        link.joy_load = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (toggle) begin
                link.joy_clk  = 1'($urandom_range(0, 1));
                link.joy_load = 1'($urandom_range(0, 1));
                joy1 = 12'($urandom_range(0, 4095));
                joy2 = 12'($urandom_range(0, 4095));
            end
        end
        @(negedge clk);
        link.joy_clk = 1'b1;
        link.joy_load = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Load, release, then 25 falls; s[0] is the pad before any fall and
    // s[k] the output after fall k. Optionally swaps joy2 mid-frame.
    task automatic capture_frame(input int h, input int change_at, input logic [11:0] new_j2,
                                 output logic [25:0] s);
        load_pulse(6);
        s[0] = link.joy_data;
        for (int k = 1; k <= 25; k++) begin
            if (k == change_at) joy2 = new_j2;
            set_clk(1'b0);
            wait_cyc(h - 1);
            s[k] = link.joy_data;
            set_clk(1'b1);
            wait_cyc(h - 1);
        end
        wait_cyc(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [25:0] s;
        int          fd0;
        int          sf0;
        int          h;
        int          nfall;

        link.joy_clk  = 1'b1;
        link.joy_load = 1'b1;

        // Pin the bit-order table with hand-derived words.
        chk("map_up", 32'(frame_of(12'hFFE, 12'hFFF)), 32'h00FFFF7F);
        chk("map_j2_11", 32'(frame_of(12'hFFF, 12'h7FF)), 32'h00FDFFFF);
        chk("map_j1_7", 32'(frame_of(12'hF7F, 12'hFFF)), 32'h007FFFFF);

        // Reset with toggling inputs, then idle.
        do_reset(3, 1'b1);
        joy1 = 12'hFFF;
        joy2 = 12'hFFF;
        wait_cyc(10);
        chk("idle_data", 32'(link.joy_data), 32'd1);
        chk("idle_state", 32'(dbg_state), 32'd0);

        // Up pressed on player 1: zero at stream index 8.
        joy1 = 12'hFFE;
        joy2 = 12'hFFF;
        fd0 = fd_count;
        capture_frame(6, 0, 12'hFFF, s);
        chk("stream_up", 32'(s), 32'h03FFFEFF);
        chk("frame_done_once", 32'(fd_count - fd0), 32'd1);
        clk_pulse(6);
        wait_cyc(4);
        chk("no_extra_done", 32'(fd_count - fd0), 32'd1);

        // j2[11] low lands at payload 17; the mid-frame change is ignored.
        joy1 = 12'hFFF;
        joy2 = 12'h7FF;
        capture_frame(5, 6, 12'hFFF, s);
        chk("stream_j2_11", 32'(s), 32'h03FBFFFF);

        // Load reasserted after 10 falls.
        joy1 = 12'hF7F;
        joy2 = 12'hFFF;
        sf0 = sf_count;
        load_pulse(6);
        for (int i = 0; i < 10; i++) clk_pulse(5);
        set_load(1'b0);
        wait_cyc(6);
        chk("short_once", 32'(sf_count - sf0), 32'd1);
        chk("short_state", 32'(dbg_state), 32'd1);
        chk("short_data", 32'(link.joy_data), 32'd1);
        set_load(1'b1);
        wait_cyc(5);
        capture_frame(5, 0, 12'hFFF, s);
        chk("restart_stream", 32'(s), 32'h02FFFFFF);

        // Load fall coincident with the 25th clk fall: shift discarded.
        fd0 = fd_count;
        sf0 = sf_count;
        load_pulse(6);
        for (int i = 0; i < 24; i++) clk_pulse(5);
        drive_pins(1'b0, 1'b0);
        wait_cyc(6);
        chk("coinc_no_done", 32'(fd_count - fd0), 32'd0);
        chk("coinc_short", 32'(sf_count - sf0), 32'd1);
        chk("coinc_data", 32'(link.joy_data), 32'd1);
        set_clk(1'b1);
        wait_cyc(4);
        set_load(1'b1);
        wait_cyc(5);
        for (int i = 0; i < 25; i++) clk_pulse(5);

        // Coincident early in a frame.
        joy1 = 12'($urandom_range(0, 4095));
        load_pulse(5);
        for (int i = 0; i < 3; i++) clk_pulse(5);
        drive_pins(1'b0, 1'b0);
        wait_cyc(6);
        set_clk(1'b1);
        wait_cyc(4);
        set_load(1'b1);
        wait_cyc(5);
        for (int i = 0; i < 25; i++) clk_pulse(5);

        // Reset mid-frame, then a clean frame.
        load_pulse(5);
        for (int i = 0; i < 7; i++) clk_pulse(5);
        do_reset(1, 1'b0);
        wait_cyc(4);
        joy1 = 12'hFFE;
        joy2 = 12'hFFF;
        capture_frame(5, 0, 12'hFFF, s);
        chk("post_reset_stream", 32'(s), 32'h03FFFEFF);

        // Random frames.
        for (int f = 0; f < 100; f++) begin
            h = $urandom_range(5, 8);
            set_load(1'b0);
            wait_cyc(2);
            joy1 = 12'($urandom_range(0, 4095));
            joy2 = 12'($urandom_range(0, 4095));
            wait_cyc($urandom_range(3, 10));
            set_load(1'b1);
            wait_cyc(5);
            nfall = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 24) : 25 + $urandom_range(0, 1);
            for (int i = 0; i < nfall; i++) begin
                if ($urandom_range(0, 7) == 0) joy1 = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 7) == 0) joy2 = 12'($urandom_range(0, 4095));
                clk_pulse(h);
            end
            if ($urandom_range(0, 19) == 0) begin
                do_reset(1, 1'b0);
                wait_cyc(3);
            end
        end

        wait_cyc(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
